// File: rtl/vga_window_gen.sv
// VGA raster timing generator with one runtime-configurable image window.
// Outputs (syncs, blank, coordinates, window address, border) are registered one cycle behind the counters.
module vga_window_gen #(
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACT    = 640,
    parameter int V_FRONT  = 11,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 31,
    parameter int V_ACT    = 480,
    parameter int CNT_W    = 11,
    parameter int ADDR_W   = 15,
    parameter int SYNC_POL = 0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [CNT_W-1:0]  win_x,
    input  logic [CNT_W-1:0]  win_y,
    input  logic [CNT_W-1:0]  win_w,
    input  logic [CNT_W-1:0]  win_h,
    input  logic              scale2x,
    input  logic              border_en,
    input  logic [3:0]        border_t,
    output logic              hsync,
    output logic              vsync,
    output logic              VGA_BLANK,
    output logic              VGA_SYNC,
    output logic [CNT_W-1:0]  px_x,
    output logic [CNT_W-1:0]  px_y,
    output logic              win_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              border,
    output logic              frame_start
);
    localparam int XW = CNT_W + 2;
    localparam logic [CNT_W-1:0] H_BLK   = CNT_W'(H_FRONT + H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_BLK   = CNT_W'(V_FRONT + V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_FRONT + H_SYNC + H_BACK + H_ACT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_FRONT + V_SYNC + V_BACK + V_ACT - 1);
    localparam logic [CNT_W-1:0] H_S0    = CNT_W'(H_FRONT);
    localparam logic [CNT_W-1:0] H_S1    = CNT_W'(H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_S0    = CNT_W'(V_FRONT);
    localparam logic [CNT_W-1:0] V_S1    = CNT_W'(V_FRONT + V_SYNC);
    localparam logic             POL     = (SYNC_POL != 0);

    logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0]  wx_q, wy_q, ww_q, wh_q;
    logic              s_q, be_q;
    logic [3:0]        bt_q;
    logic [ADDR_W-1:0] base_q, base_d;

    logic              hsync_q, vsync_q, blank_q, valid_q, border_q, fs_q;
    logic              hsync_d, vsync_d, blank_d, valid_d, border_d, fs_d;
    logic [CNT_W-1:0]  px_x_q, px_y_q, px_x_d, px_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              h_last, frame_top, h_act, v_act, act;
    logic              in_x, in_y, bx, by, nonempty, row_odd;
    logic [CNT_W-1:0]  x_rel, y_rel, col;
    logic [CNT_W:0]    dw, dh;
    logic [XW-1:0]     xe, ye, wxe, wye, dwe, dhe, te;

    always_comb begin
        h_last    = (h_q == H_LAST);
        frame_top = (h_q == '0) && (v_q == '0);
        h_d       = h_last ? '0 : h_q + 1'b1;
        v_d       = v_q;
        if (h_last) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;

        h_act = (h_q >= H_BLK);
        v_act = (v_q >= V_BLK);
        act   = h_act && v_act;
        x_rel = h_q - H_BLK;
        y_rel = v_q - V_BLK;

        // Displayed extent and edges widened so x+w never wraps.
        dw  = {1'b0, ww_q} << s_q;
        dh  = {1'b0, wh_q} << s_q;
        xe  = {2'b00, x_rel};
        ye  = {2'b00, y_rel};
        wxe = {2'b00, wx_q};
        wye = {2'b00, wy_q};
        dwe = {1'b0, dw};
        dhe = {1'b0, dh};
        te  = XW'(bt_q);

        in_x     = (xe >= wxe) && (xe < wxe + dwe);
        in_y     = (ye >= wye) && (ye < wye + dhe);
        bx       = (xe + te >= wxe) && (xe < wxe + dwe + te);
        by       = (ye + te >= wye) && (ye < wye + dhe + te);
        nonempty = (ww_q != '0) && (wh_q != '0);
        row_odd  = y_rel[0] ^ wy_q[0];
        col      = (x_rel - wx_q) >> s_q;

        hsync_d  = ((h_q >= H_S0) && (h_q < H_S1)) ? POL : ~POL;
        vsync_d  = ((v_q >= V_S0) && (v_q < V_S1)) ? POL : ~POL;
        blank_d  = act;
        px_x_d   = act ? x_rel : '0;
        px_y_d   = act ? y_rel : '0;
        valid_d  = act && in_x && in_y;
        addr_d   = valid_d ? base_q + ADDR_W'(col) : '0;
        border_d = be_q && act && !valid_d && (bt_q != 4'd0) && nonempty && bx && by;
        fs_d     = frame_top;

        // Line base advances after each displayed row that ends a source row.
        base_d = base_q;
        if (frame_top)
            base_d = '0;
        else if (h_last && v_act && in_y && (!s_q || row_odd))
            base_d = base_q + ADDR_W'(ww_q);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            wx_q     <= '0;
            wy_q     <= '0;
            ww_q     <= '0;
            wh_q     <= '0;
            s_q      <= 1'b0;
            be_q     <= 1'b0;
            bt_q     <= '0;
            base_q   <= '0;
            hsync_q  <= ~POL;
            vsync_q  <= ~POL;
            blank_q  <= 1'b0;
            px_x_q   <= '0;
            px_y_q   <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            border_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            base_q   <= base_d;
            if (frame_top) begin
                wx_q <= win_x;
                wy_q <= win_y;
                ww_q <= win_w;
                wh_q <= win_h;
                s_q  <= scale2x;
                be_q <= border_en;
                bt_q <= border_t;
            end
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            px_x_q   <= px_x_d;
            px_y_q   <= px_y_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            border_q <= border_d;
            fs_q     <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign VGA_BLANK   = blank_q;
    assign VGA_SYNC    = 1'b1;
    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign win_valid   = valid_q;
    assign addr        = addr_q;
    assign border      = border_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_window_gen.sv
// Randomized bench for vga_window_gen on a shrunken raster, checked per pixel against an arithmetic model.
module tb_vga_window_gen;
    localparam int HF = 4, HS = 6, HBK = 5, HA = 40;
    localparam int VF = 2, VS = 2, VBK = 3, VA = 20;
    localparam int HT = HF + HS + HBK + HA;
    localparam int VT = VF + VS + VBK + VA;
    localparam int HB = HF + HS + HBK;
    localparam int VB = VF + VS + VBK;
    localparam int FRAME = HT * VT;
    localparam int CW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] win_x = '0, win_y = '0, win_w = '0, win_h = '0;
    logic          scale2x = 1'b0, border_en = 1'b0;
    logic [3:0]    border_t = '0;
    logic          hsync, vsync, vga_blank, vga_sync, win_valid, border, frame_start;
    logic [CW-1:0] px_x, px_y;
    logic [AW-1:0] addr;

    int n_checks = 0;
    int n_errors = 0;

    vga_window_gen #(
        .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK), .H_ACT(HA),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK), .V_ACT(VA),
        .CNT_W(CW), .ADDR_W(AW), .SYNC_POL(0)
    ) dut (
        .CLK(clk), .reset(reset),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .scale2x(scale2x), .border_en(border_en), .border_t(border_t),
        .hsync(hsync), .vsync(vsync), .VGA_BLANK(vga_blank), .VGA_SYNC(vga_sync),
        .px_x(px_x), .px_y(px_y), .win_valid(win_valid), .addr(addr),
        .border(border), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected word: {vga_sync, hs, vs, blank, fs, valid, border, px_x, px_y, addr}
    logic [30:0] exp_q[$];

    int m_h = 0, m_v = 0;
    int s_wx, s_wy, s_ww, s_wh, s_sc, s_be, s_bt;

    always @(posedge clk) begin
        logic [30:0] e;
        int px, py, dw, dh, dx, dy, a;
        bit act, hs, vs, valid, bord, fs;
        if (reset) begin
            e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0};
            m_h = 0;
            m_v = 0;
        end else begin
            fs = (m_h == 0) && (m_v == 0);
            if (fs) begin
                s_wx = int'(win_x); s_wy = int'(win_y);
                s_ww = int'(win_w); s_wh = int'(win_h);
                s_sc = int'(scale2x); s_be = int'(border_en); s_bt = int'(border_t);
            end
            hs  = !(m_h >= HF && m_h < HF + HS);
            vs  = !(m_v >= VF && m_v < VF + VS);
            act = (m_h >= HB) && (m_v >= VB);
            px  = act ? m_h - HB : 0;
            py  = act ? m_v - VB : 0;
            dw  = s_ww * (s_sc ? 2 : 1);
            dh  = s_wh * (s_sc ? 2 : 1);
            valid = act && px >= s_wx && px < s_wx + dw && py >= s_wy && py < s_wy + dh;
            a = 0;
            if (valid)
                a = (((py - s_wy) / (s_sc ? 2 : 1)) * s_ww + (px - s_wx) / (s_sc ? 2 : 1)) % (1 << AW);
            dx = (px < s_wx) ? s_wx - px : ((px >= s_wx + dw) ? px - (s_wx + dw - 1) : 0);
            dy = (py < s_wy) ? s_wy - py : ((py >= s_wy + dh) ? py - (s_wy + dh - 1) : 0);
            bord = (s_be != 0) && act && !valid && s_bt > 0 && dw > 0 && dh > 0 &&
                   dx <= s_bt && dy <= s_bt;
            e = {1'b1, hs, vs, act, fs, valid, bord, 8'(px), 8'(py), 8'(a)};
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
        end
        exp_q.push_back(e);
    end

    int  fr_cnt = 0;
    bit  fr_seen = 0;

    always @(negedge clk) begin
        logic [30:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sync", {27'd0, vga_sync, hsync, vsync, vga_blank, frame_start}, {27'd0, e[30:26]});
            check("win",  {30'd0, win_valid, border}, {30'd0, e[25:24]});
            check("pix",  {16'd0, px_x, px_y}, {16'd0, e[23:8]});
            check("addr", {24'd0, addr}, {24'd0, e[7:0]});
        end
        if (reset) begin
            fr_seen = 0;
            fr_cnt  = 0;
        end else begin
            fr_cnt++;
            if (frame_start) begin
                if (fr_seen) check("frame_period", fr_cnt, FRAME);
                fr_seen = 1;
                fr_cnt  = 0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input int x, input int y, input int w, input int h,
                           input bit s, input bit be, input int t);
        @(negedge clk);
        win_x = CW'(x); win_y = CW'(y); win_w = CW'(w); win_h = CW'(h);
        scale2x = s; border_en = be; border_t = 4'(t);
    endtask

    initial begin
        set_cfg(8, 5, 12, 10, 0, 0, 0);
        reset = 1'b1;
        cycles(5);
        reset = 1'b0;
        cycles(2 * FRAME);

        set_cfg(8, 5, 12, 5, 1, 0, 0);
        cycles(2 * FRAME);
        set_cfg(10, 10, 4, 4, 0, 1, 2);
        cycles(2 * FRAME);

        // Mid-frame move must only take effect on the following frame.
        set_cfg(8, 5, 12, 10, 0, 1, 3);
        cycles(FRAME + 700);
        win_x = CW'(20);
        cycles(2 * FRAME);

        set_cfg(35, 15, 10, 10, 0, 1, 4);
        cycles(2 * FRAME);
        set_cfg(3, 3, 0, 5, 0, 1, 2);
        cycles(2 * FRAME);

        set_cfg(6, 2, 30, 20, 0, 1, 1);
        cycles(500);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(2 * FRAME);

        for (int i = 0; i < 6; i++) begin
            set_cfg($urandom_range(0, 45), $urandom_range(0, 25), $urandom_range(0, 40),
                    $urandom_range(0, 22), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15));
            cycles($urandom_range(100, FRAME));
            win_x = CW'($urandom_range(0, 45));
            win_w = CW'($urandom_range(0, 40));
            cycles(FRAME + 50);
        end

        cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
